// File: rtl/wb_reg_slave_pkg.sv
// Shared register map, identification constant and bus FSM state encoding
// for the Wishbone register slave.
package wb_reg_pkg;

    // Byte offsets of the fixed registers; the GP bank starts at GP_BASE_ADR.
    localparam logic [7:0] CTRL_ADR     = 8'h00;
    localparam logic [7:0] INT_SRC_ADR  = 8'h04;
    localparam logic [7:0] INT_MASK_ADR = 8'h08;
    localparam logic [7:0] ID_ADR       = 8'h0C;
    localparam logic [7:0] GP_BASE_ADR  = 8'h10;

    localparam logic [31:0] ID_VALUE = 32'h57B0_0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_reg_slave_if.sv
// Wishbone classic bus bundle: 8-bit byte address, 32-bit data.
interface wb_reg_slave_if;

    logic [7:0]  adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;

    modport master (
        output adr, wdat, we, stb, cyc,
        input  rdat, ack
    );

    modport slave (
        input  adr, wdat, we, stb, cyc,
        output rdat, ack
    );

endinterface

// File: rtl/wb_irq_ctrl.sv
// Interrupt source/mask storage with write-one-to-clear sources (a new event
// beats a clear on the same edge) and a registered, enable-gated level output.
module wb_irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               src_we,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] wdat,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               ie,
    output logic [31:0]        src_rd,
    output logic [31:0]        mask_rd,
    output logic               int_o
);
    import wb_reg_pkg::*;

    logic [NUM_IRQ-1:0] src_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] clr_bits;
    logic               int_q;

    assign clr_bits = src_we ? wdat : '0;

    // Sources: clear the written ones, then OR in this edge's events so set wins.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            src_q <= '0;
        end else begin
            src_q <= (src_q & ~clr_bits) | irq_src;
        end
    end

    // Mask is plain storage.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mask_q <= '0;
        end else if (mask_we) begin
            mask_q <= wdat;
        end
    end

    // Output level follows register state one edge late.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            int_q <= 1'b0;
        end else begin
            int_q <= ie & (|(src_q & mask_q));
        end
    end

    // Zero-extend the implemented bits to the bus width.
    always_comb begin
        src_rd                = '0;
        mask_rd               = '0;
        src_rd[NUM_IRQ-1:0]   = src_q;
        mask_rd[NUM_IRQ-1:0]  = mask_q;
    end

    assign int_o = int_q;

endmodule

// File: rtl/wb_reg_slave.sv
// Wishbone classic-cycle register slave: CTRL, interrupt source/mask, ID and a
// bank of general-purpose registers, with a programmable number of wait states
// before the single-cycle acknowledge.
//
// state | meaning
// IDLE  | waiting for cyc & stb; request fields latched when seen
// WAIT  | counting wait states; request drop aborts without ack or write
// ACK   | ack high for one cycle with registered read data; back to IDLE
module wb_reg_slave #(
    parameter int NUM_GP      = 4,
    parameter int WAIT_STATES = 0,
    parameter int NUM_IRQ     = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_reg_slave_if.slave      bus,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    output logic               wb_int_o
);
    import wb_reg_pkg::*;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_ACK  = ACK;

    localparam logic [5:0] CTRL_W     = CTRL_ADR[7:2];
    localparam logic [5:0] INT_SRC_W  = INT_SRC_ADR[7:2];
    localparam logic [5:0] INT_MASK_W = INT_MASK_ADR[7:2];
    localparam logic [5:0] ID_W       = ID_ADR[7:2];
    localparam logic [5:0] GP_W       = GP_BASE_ADR[7:2];

    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [1:0]  state_q;
    logic [3:0]  wait_cnt_q;
    logic [5:0]  lat_adr_q;
    logic        lat_we_q;
    logic [31:0] lat_dat_q;
    logic [31:0] rdat_q;
    logic [31:0] ctrl_q;
    logic [31:0] gp_q [NUM_GP];

    logic        req;
    logic        go_ack;
    logic        from_idle;
    logic [5:0]  acc_adr;
    logic        acc_we;
    logic [31:0] acc_dat;
    logic        wr_en;
    logic        hit_ctrl;
    logic        hit_src;
    logic        hit_mask;
    logic        hit_id;
    logic        gp_hit;
    logic [6:0]  gp_off;
    logic [31:0] rd_mux;
    logic [31:0] src_rd;
    logic [31:0] mask_rd;
    logic        unused_adr_lo;

    assign req           = bus.cyc & bus.stb;
    assign from_idle     = (state_q == ST_IDLE);
    assign unused_adr_lo = ^bus.adr[1:0];

    // With zero wait states the ACK entry happens on the sampling edge itself,
    // so the access fields come straight from the bus instead of the latches.
    always_comb begin
        go_ack = 1'b0;
        if (state_q == ST_IDLE) begin
            go_ack = req && (WAIT_STATES == 0);
        end else if (state_q == ST_WAIT) begin
            go_ack = req && (wait_cnt_q == 4'd0);
        end
    end

    assign acc_adr = from_idle ? bus.adr[7:2] : lat_adr_q;
    assign acc_we  = from_idle ? bus.we       : lat_we_q;
    assign acc_dat = from_idle ? bus.wdat     : lat_dat_q;
    assign wr_en   = go_ack & acc_we;

    assign hit_ctrl = (acc_adr == CTRL_W);
    assign hit_src  = (acc_adr == INT_SRC_W);
    assign hit_mask = (acc_adr == INT_MASK_W);
    assign hit_id   = (acc_adr == ID_W);
    assign gp_off   = {1'b0, acc_adr} - {1'b0, GP_W};
    assign gp_hit   = (acc_adr >= GP_W) && (gp_off < 7'(NUM_GP));

    // Read selection; unmapped words read as zero.
    always_comb begin
        rd_mux = '0;
        if (hit_ctrl) begin
            rd_mux = ctrl_q;
        end else if (hit_src) begin
            rd_mux = src_rd;
        end else if (hit_mask) begin
            rd_mux = mask_rd;
        end else if (hit_id) begin
            rd_mux = ID_VALUE;
        end else if (gp_hit) begin
            for (int n = 0; n < NUM_GP; n++) begin
                if (gp_off == 7'(n)) begin
                    rd_mux = gp_q[n];
                end
            end
        end
    end

    // Bus FSM, wait counter and request latches.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            lat_adr_q  <= '0;
            lat_we_q   <= 1'b0;
            lat_dat_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        lat_adr_q  <= bus.adr[7:2];
                        lat_we_q   <= bus.we;
                        lat_dat_q  <= bus.wdat;
                        wait_cnt_q <= WAIT_INIT;
                        if (WAIT_STATES == 0) begin
                            state_q <= ST_ACK;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state_q    <= ST_IDLE;
                        wait_cnt_q <= 4'd0;
                    end else if (wait_cnt_q == 4'd0) begin
                        state_q <= ST_ACK;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data is captured on ACK entry and forced to zero otherwise.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rdat_q <= '0;
        end else begin
            rdat_q <= go_ack ? rd_mux : '0;
        end
    end

    // CTRL register; bit 0 enables the interrupt output.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl_q <= '0;
        end else if (wr_en && hit_ctrl) begin
            ctrl_q <= acc_dat;
        end
    end

    // General-purpose register bank.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int n = 0; n < NUM_GP; n++) begin
                gp_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_GP; n++) begin
                if (wr_en && gp_hit && (gp_off == 7'(n))) begin
                    gp_q[n] <= acc_dat;
                end
            end
        end
    end

    wb_irq_ctrl #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .src_we   (wr_en & hit_src),
        .mask_we  (wr_en & hit_mask),
        .wdat     (acc_dat[NUM_IRQ-1:0]),
        .irq_src  (irq_src_i),
        .ie       (ctrl_q[0]),
        .src_rd   (src_rd),
        .mask_rd  (mask_rd),
        .int_o    (wb_int_o)
    );

    assign bus.ack  = (state_q == ST_ACK);
    assign bus.rdat = rdat_q;

endmodule

// File: tb/tb_wb_reg_slave.sv
// Directed bench for wb_reg_slave: one instance with no wait states, one with
// three wait states, sharing clock and reset.
module tb_wb_reg_slave;
    import wb_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq0;
    logic [7:0] irq3;
    logic       int0;
    logic       int3;
    logic       int_at_ack;
    logic       int_after;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    wb_reg_slave_if bus0();
    wb_reg_slave_if bus3();

    wb_reg_slave #(.NUM_GP(4), .WAIT_STATES(0), .NUM_IRQ(8)) dut0 (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .bus       (bus0),
        .irq_src_i (irq0),
        .wb_int_o  (int0)
    );

    wb_reg_slave #(.NUM_GP(4), .WAIT_STATES(3), .NUM_IRQ(8)) dut3 (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .bus       (bus3),
        .irq_src_i (irq3),
        .wb_int_o  (int3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle0();
        bus0.cyc = 1'b0; bus0.stb = 1'b0; bus0.we = 1'b0;
    endtask

    task automatic idle3();
        bus3.cyc = 1'b0; bus3.stb = 1'b0; bus3.we = 1'b0;
    endtask

    // Zero-wait read: ack and data in the cycle after the sampling edge.
    task automatic rd0(input logic [7:0] a, input logic [31:0] exp, input string tag);
        bus0.adr = a; bus0.we = 1'b0; bus0.cyc = 1'b1; bus0.stb = 1'b1;
        @(negedge clk);
        check({tag, " ack"}, 32'(bus0.ack), 32'd1);
        check({tag, " dat"}, bus0.rdat, exp);
        idle0();
        @(negedge clk);
        check({tag, " ack low"}, 32'(bus0.ack), 32'd0);
        check({tag, " dat low"}, bus0.rdat, 32'd0);
    endtask

    // Zero-wait write; records the interrupt level in the ack and following cycle.
    task automatic wr0(input logic [7:0] a, input logic [31:0] d, input string tag);
        bus0.adr = a; bus0.wdat = d; bus0.we = 1'b1; bus0.cyc = 1'b1; bus0.stb = 1'b1;
        @(negedge clk);
        check({tag, " ack"}, 32'(bus0.ack), 32'd1);
        int_at_ack = int0;
        idle0();
        @(negedge clk);
        check({tag, " ack low"}, 32'(bus0.ack), 32'd0);
        int_after = int0;
    endtask

    // Three-wait access: ack must appear exactly on the fourth cycle.
    task automatic acc3(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string tag);
        bus3.adr = a; bus3.wdat = d; bus3.we = w; bus3.cyc = 1'b1; bus3.stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, " wait ack"}, 32'(bus3.ack), 32'd0);
        end
        @(negedge clk);
        check({tag, " ack"}, 32'(bus3.ack), 32'd1);
        if (!w) check({tag, " dat"}, bus3.rdat, exp);
        idle3();
        @(negedge clk);
        check({tag, " ack low"}, 32'(bus3.ack), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        irq0 = '0; irq3 = '0;
        bus0.adr = '0; bus0.wdat = '0; idle0();
        bus3.adr = '0; bus3.wdat = '0; idle3();
        repeat (3) @(negedge clk);
        check("rst ack", 32'(bus0.ack), 32'd0);
        check("rst dat", bus0.rdat, 32'd0);
        check("rst int", 32'(int0), 32'd0);
        rst = 1'b0;

        rd0(8'h0C, ID_VALUE, "id");
        rd0(8'h00, 32'd0, "ctrl reset");
        rd0(8'h10, 32'd0, "gp0 reset");

        // write GP1 then read it with the strobe held
        bus0.adr = 8'h14; bus0.wdat = 32'hDEAD_BEEF; bus0.we = 1'b1;
        bus0.cyc = 1'b1; bus0.stb = 1'b1;
        @(negedge clk);
        check("b2b wr ack", 32'(bus0.ack), 32'd1);
        bus0.we = 1'b0;
        @(negedge clk);
        check("b2b dead cycle", 32'(bus0.ack), 32'd0);
        @(negedge clk);
        check("b2b rd ack", 32'(bus0.ack), 32'd1);
        check("b2b rd dat", bus0.rdat, 32'hDEAD_BEEF);
        idle0();
        @(negedge clk);
        check("b2b ack low", 32'(bus0.ack), 32'd0);

        rd0(8'h10, 32'd0, "gp0 untouched");
        rd0(8'h17, 32'hDEAD_BEEF, "gp1 alias");
        wr0(8'h0C, 32'd0, "id wr");
        rd0(8'h0C, ID_VALUE, "id ro");
        wr0(8'h20, 32'hFFFF_FFFF, "past gp wr");
        rd0(8'h20, 32'd0, "past gp rd");
        rd0(8'h1C, 32'd0, "gp3 untouched");
        wr0(8'h80, 32'h1234_5678, "unmapped wr");
        rd0(8'h80, 32'd0, "unmapped rd");

        acc3(1'b1, 8'h10, 32'h1234_5678, 32'd0, "ws3 wr");
        acc3(1'b0, 8'h10, 32'd0, 32'h1234_5678, "ws3 rd");

        // abort a waited write by dropping the strobe
        bus3.adr = 8'h10; bus3.wdat = 32'hFFFF_FFFF; bus3.we = 1'b1;
        bus3.cyc = 1'b1; bus3.stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        idle3();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ws3 abort no ack", 32'(bus3.ack), 32'd0);
        end
        acc3(1'b0, 8'h10, 32'd0, 32'h1234_5678, "ws3 abort kept");

        // interrupts
        irq0 = 8'h04;
        @(negedge clk);
        irq0 = 8'h00;
        check("int masked", 32'(int0), 32'd0);
        rd0(8'h04, 32'h04, "src captured");
        wr0(8'h08, 32'h04, "mask wr");
        rd0(8'h08, 32'h04, "mask rd");
        wr0(8'h00, 32'h8000_0001, "ctrl ie");
        check("int before ie edge", 32'(int_at_ack), 32'd0);
        check("int after ie edge", 32'(int_after), 32'd1);
        rd0(8'h00, 32'h8000_0001, "ctrl rd");
        wr0(8'h04, 32'h04, "w1c");
        check("int during w1c ack", 32'(int_at_ack), 32'd1);
        check("int after w1c", 32'(int_after), 32'd0);
        rd0(8'h04, 32'd0, "src cleared");

        irq0 = 8'h04;
        @(negedge clk);
        @(negedge clk);
        check("int reasserted", 32'(int0), 32'd1);
        wr0(8'h04, 32'hFFFF_FFFF, "w1c vs set");
        check("set wins int ack", 32'(int_at_ack), 32'd1);
        check("set wins int after", 32'(int_after), 32'd1);
        irq0 = 8'h00;
        rd0(8'h04, 32'h04, "set wins src");
        wr0(8'h08, 32'hFFFF_FFFF, "mask all");
        rd0(8'h08, 32'h0000_00FF, "mask width");
        check("int before reset", 32'(int0), 32'd1);

        // reset with dut0 in ACK and dut3 in WAIT
        bus0.adr = 8'h0C; bus0.we = 1'b0; bus0.cyc = 1'b1; bus0.stb = 1'b1;
        bus3.adr = 8'h10; bus3.we = 1'b0; bus3.cyc = 1'b1; bus3.stb = 1'b1;
        @(negedge clk);
        check("pre-rst ack0", 32'(bus0.ack), 32'd1);
        check("pre-rst dat0", bus0.rdat, ID_VALUE);
        check("pre-rst ack3", 32'(bus3.ack), 32'd0);
        rst = 1'b1;
        idle0();
        idle3();
        #1;
        check("rst ack0", 32'(bus0.ack), 32'd0);
        check("rst dat0", bus0.rdat, 32'd0);
        check("rst int0", 32'(int0), 32'd0);
        check("rst ack3", 32'(bus3.ack), 32'd0);
        check("rst dat3", bus3.rdat, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        rd0(8'h00, 32'd0, "ctrl after rst");
        rd0(8'h14, 32'd0, "gp1 after rst");
        rd0(8'h08, 32'd0, "mask after rst");
        rd0(8'h04, 32'd0, "src after rst");
        rd0(8'h80, 32'd0, "unmapped after rst");
        acc3(1'b0, 8'h10, 32'd0, 32'd0, "ws3 gp0 after rst");
        check("int0 after rst", 32'(int0), 32'd0);
        check("int3 idle", 32'(int3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
